// File: rtl/pio_pkg.sv
// Shared constants for the PIO FIFO pair: join-mode encodings and err bit positions.
package pio_pkg;

    localparam logic [1:0] JOIN_NONE = 2'd0;
    localparam logic [1:0] JOIN_TX   = 2'd1;
    localparam logic [1:0] JOIN_RX   = 2'd2;

    localparam int ERR_TX_OVER  = 0;
    localparam int ERR_TX_UNDER = 1;
    localparam int ERR_RX_OVER  = 2;
    localparam int ERR_RX_UNDER = 3;

    // Encoding 3 is reserved and behaves like JOIN_NONE.
    function automatic logic [1:0] join_norm(input logic [1:0] j);
        return (j == 2'd3) ? JOIN_NONE : j;
    endfunction

endpackage

// File: rtl/pio_fifo_ctrl.sv
// Pointer/count/flag control for one FIFO whose capacity is supplied at run time.
// The count port exists only when PIO_FIFO_LEVEL_EN is defined.
module pio_fifo_ctrl
    import pio_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(2*DEPTH),
    parameter int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic [LW-1:0] cap,
    input  logic          push,
    input  logic          pull,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic          full,
    output logic          empty,
    output logic          push_ok,
    output logic          over,
    output logic          under
`ifdef PIO_FIFO_LEVEL_EN
    ,
    output logic [LW-1:0] count
`endif
);

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0] count_reg, count_next;
    logic          full_reg, empty_reg;
    logic          pull_ok;

    always_comb begin
        pull_ok     = pull && !flush && !empty_reg;
        // A full FIFO still takes a push when a pull frees a slot in the same cycle.
        push_ok     = push && !flush && (cap != '0) && (!full_reg || pull_ok);
        over        = push && !flush && !push_ok;
        under       = pull && !flush && empty_reg;
        count_next  = count_reg + LW'(push_ok) - LW'(pull_ok);
        wr_ptr_next = ((LW'(wr_ptr_reg) + LW'(1)) == cap) ? '0 : wr_ptr_reg + AW'(1);
        rd_ptr_next = ((LW'(rd_ptr_reg) + LW'(1)) == cap) ? '0 : rd_ptr_reg + AW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_next;
            if (pull_ok) rd_ptr_reg <= rd_ptr_next;
            count_reg <= count_next;
            full_reg  <= (cap != '0) && (count_next == cap);
            empty_reg <= (count_next == '0);
        end
    end

    // A zero-capacity side is permanently full as well as empty.
    assign full   = full_reg | (cap == '0);
    assign empty  = empty_reg;
    assign wr_ptr = wr_ptr_reg;
    assign rd_ptr = rd_ptr_reg;
`ifdef PIO_FIFO_LEVEL_EN
    assign count  = count_reg;
`endif

endmodule

// File: rtl/pio_fifo_pair.sv
// Per-state-machine TX/RX FIFO pair sharing one 2*DEPTH word store, with join modes and sticky errors.
// Define PIO_FIFO_LEVEL_EN to expose tx_level/rx_level word counts.
module pio_fifo_pair
    import pio_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 join_mode,
    input  logic                       flush,
    input  logic                       tx_push,
    input  logic [WIDTH-1:0]           tx_wdata,
    output logic                       tx_full,
    input  logic                       tx_pull,
    output logic [WIDTH-1:0]           tx_rdata,
    output logic                       tx_empty,
    input  logic                       rx_push,
    input  logic [WIDTH-1:0]           rx_wdata,
    output logic                       rx_full,
    input  logic                       rx_pull,
    output logic [WIDTH-1:0]           rx_rdata,
    output logic                       rx_empty,
    input  logic                       err_clr,
    output logic [3:0]                 err
`ifdef PIO_FIFO_LEVEL_EN
    ,
    output logic [$clog2(2*DEPTH):0]   tx_level,
    output logic [$clog2(2*DEPTH):0]   rx_level
`endif
);

    localparam int AW = $clog2(2*DEPTH);
    localparam int LW = AW + 1;

    // Index 0 is the TX side, index 1 the RX side.
    logic [1:0]       side_push, side_pull, side_full, side_empty;
    logic [1:0]       side_push_ok, side_over, side_under;
    logic [WIDTH-1:0] side_wdata [2];
    logic [WIDTH-1:0] side_rdata [2];
    logic [LW-1:0]    side_cap   [2];
    logic [AW-1:0]    side_base  [2];
    logic [AW-1:0]    side_wr_ptr[2];
    logic [AW-1:0]    side_rd_ptr[2];
    logic [AW-1:0]    side_waddr [2];
    logic [AW-1:0]    side_raddr [2];
`ifdef PIO_FIFO_LEVEL_EN
    logic [LW-1:0]    side_count [2];
`endif

    logic [WIDTH-1:0] mem [0:2*DEPTH-1];
    logic [1:0]       join_reg, join_eff;
    logic             flush_int;
    logic [3:0]       err_reg, err_new;

    // A join change clears both FIFOs at the same edge the new mode is latched.
    assign join_eff  = join_norm(join_mode);
    assign flush_int = flush | (join_eff != join_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) join_reg <= JOIN_NONE;
        else          join_reg <= join_eff;
    end

    always_comb begin
        side_cap[0]  = LW'(DEPTH);
        side_cap[1]  = LW'(DEPTH);
        side_base[0] = '0;
        side_base[1] = AW'(DEPTH);
        case (join_reg)
            JOIN_TX: begin
                side_cap[0] = LW'(2*DEPTH);
                side_cap[1] = '0;
            end
            JOIN_RX: begin
                side_cap[0]  = '0;
                side_cap[1]  = LW'(2*DEPTH);
                side_base[1] = '0;
            end
            default: ;
        endcase
    end

    assign side_push     = {rx_push, tx_push};
    assign side_pull     = {rx_pull, tx_pull};
    assign side_wdata[0] = tx_wdata;
    assign side_wdata[1] = rx_wdata;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            pio_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
                .clk     (clk),
                .reset_n (reset_n),
                .flush   (flush_int),
                .cap     (side_cap[gi]),
                .push    (side_push[gi]),
                .pull    (side_pull[gi]),
                .wr_ptr  (side_wr_ptr[gi]),
                .rd_ptr  (side_rd_ptr[gi]),
                .full    (side_full[gi]),
                .empty   (side_empty[gi]),
                .push_ok (side_push_ok[gi]),
                .over    (side_over[gi]),
                .under   (side_under[gi])
`ifdef PIO_FIFO_LEVEL_EN
                ,
                .count   (side_count[gi])
`endif
            );
            assign side_waddr[gi] = side_base[gi] + side_wr_ptr[gi];
            assign side_raddr[gi] = side_base[gi] + side_rd_ptr[gi];
            assign side_rdata[gi] = side_empty[gi] ? '0 : mem[side_raddr[gi]];
        end
    endgenerate

    // The two sides always address disjoint words, so both writes can land in one cycle.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (side_push_ok[s]) mem[side_waddr[s]] <= side_wdata[s];
        end
    end

    always_comb begin
        err_new               = '0;
        err_new[ERR_TX_OVER]  = side_over[0];
        err_new[ERR_TX_UNDER] = side_under[0];
        err_new[ERR_RX_OVER]  = side_over[1];
        err_new[ERR_RX_UNDER] = side_under[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_reg <= '0;
        else          err_reg <= (err_clr ? 4'd0 : err_reg) | err_new;
    end

    assign tx_full  = side_full[0];
    assign tx_empty = side_empty[0];
    assign tx_rdata = side_rdata[0];
    assign rx_full  = side_full[1];
    assign rx_empty = side_empty[1];
    assign rx_rdata = side_rdata[1];
    assign err      = err_reg;

`ifdef PIO_FIFO_LEVEL_EN
    assign tx_level = side_count[0];
    assign rx_level = side_count[1];
`else
    // Word counts remain internal to the controllers.
`endif

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Self-checking bench for pio_fifo_pair: directed scenarios plus randomized traffic against a queue model.
module tb_pio_fifo_pair;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       join_mode;
    logic             flush;
    logic             tx_push, tx_pull, rx_push, rx_pull, err_clr;
    logic [WIDTH-1:0] tx_wdata, rx_wdata;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic [WIDTH-1:0] tx_rdata, rx_rdata;
    logic [3:0]       err;
`ifdef PIO_FIFO_LEVEL_EN
    logic [$clog2(2*DEPTH):0] tx_level, rx_level;
`endif

    pio_fifo_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .join_mode (join_mode),
        .flush     (flush),
        .tx_push   (tx_push),
        .tx_wdata  (tx_wdata),
        .tx_full   (tx_full),
        .tx_pull   (tx_pull),
        .tx_rdata  (tx_rdata),
        .tx_empty  (tx_empty),
        .rx_push   (rx_push),
        .rx_wdata  (rx_wdata),
        .rx_full   (rx_full),
        .rx_pull   (rx_pull),
        .rx_rdata  (rx_rdata),
        .rx_empty  (rx_empty),
        .err_clr   (err_clr),
        .err       (err)
`ifdef PIO_FIFO_LEVEL_EN
        ,
        .tx_level  (tx_level),
        .rx_level  (rx_level)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference model: plain queues per side, the current mode and the sticky flags.
    logic [WIDTH-1:0] tx_q[$];
    logic [WIDTH-1:0] rx_q[$];
    int               m_mode;
    logic [3:0]       m_err;

    function automatic int cap_of(int mode, int side);
        if (mode == 1) return (side == 0) ? 2*DEPTH : 0;
        if (mode == 2) return (side == 0) ? 0 : 2*DEPTH;
        return DEPTH;
    endfunction

    function automatic logic [WIDTH-1:0] head(int side);
        if (side == 0) return (tx_q.size() > 0) ? tx_q[0] : '0;
        return (rx_q.size() > 0) ? rx_q[0] : '0;
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_mode = 0;
        m_err  = '0;
    endtask

    task automatic idle();
        flush   = 1'b0;
        tx_push = 1'b0;
        tx_pull = 1'b0;
        rx_push = 1'b0;
        rx_pull = 1'b0;
        err_clr = 1'b0;
    endtask

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic step();
        int   jn, ctx, crx;
        bit   pa, ps;
        logic [3:0] e;
        jn = (join_mode == 2'd3) ? 0 : int'(join_mode);
        e  = '0;
        if (flush || jn != m_mode) begin
            tx_q.delete();
            rx_q.delete();
            m_mode = jn;
        end else begin
            ctx = cap_of(m_mode, 0);
            crx = cap_of(m_mode, 1);
            pa = tx_pull && tx_q.size() > 0;
            ps = tx_push && ctx > 0 && (tx_q.size() < ctx || pa);
            if (tx_pull && !pa) e[1] = 1'b1;
            if (tx_push && !ps) e[0] = 1'b1;
            if (pa) void'(tx_q.pop_front());
            if (ps) tx_q.push_back(tx_wdata);
            pa = rx_pull && rx_q.size() > 0;
            ps = rx_push && crx > 0 && (rx_q.size() < crx || pa);
            if (rx_pull && !pa) e[3] = 1'b1;
            if (rx_push && !ps) e[2] = 1'b1;
            if (pa) void'(rx_q.pop_front());
            if (ps) rx_q.push_back(rx_wdata);
        end
        m_err = (err_clr ? 4'd0 : m_err) | e;
        @(posedge clk);
        #1;
        cyc++;
        $display("[%0d] join=%0d fl=%b tx p/q=%b%b rx p/q=%b%b clr=%b -> tx_n=%0d rx_n=%0d err=%b",
                 cyc, join_mode, flush, tx_push, tx_pull, rx_push, rx_pull, err_clr,
                 tx_q.size(), rx_q.size(), err);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        join_mode = 2'd0;
        tx_wdata  = '0;
        rx_wdata  = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (tx_empty !== 1'b1 || rx_empty !== 1'b1) $display("FAIL reset_empty act=%b%b exp=11", tx_empty, rx_empty); else passed++;
        total++; if (tx_full !== 1'b0 || rx_full !== 1'b0) $display("FAIL reset_full act=%b%b exp=00", tx_full, rx_full); else passed++;
        total++; if (tx_rdata !== '0 || rx_rdata !== '0 || err !== 4'd0) $display("FAIL reset_data act=%h/%h/%b exp=0/0/0", tx_rdata, rx_rdata, err); else passed++;
        reset_n = 1'b1;
        step();
        total++; if (tx_empty !== 1'b1 || rx_full !== 1'b0) $display("FAIL reset_idle act=%b%b exp=10", tx_empty, rx_full); else passed++;
    endtask

    task automatic test_basic_tx();
        for (int i = 1; i <= 4; i++) begin
            tx_push = 1'b1; tx_wdata = WIDTH'(i);
            step();
            total++; if (tx_full !== (i == 4)) $display("FAIL t1_full_%0d act=%b exp=%b", i, tx_full, (i == 4)); else passed++;
        end
        idle();
        for (int i = 1; i <= 4; i++) begin
            total++; if (tx_rdata !== WIDTH'(i)) $display("FAIL t1_rdata_%0d act=%h exp=%h", i, tx_rdata, i); else passed++;
            tx_pull = 1'b1;
            step();
        end
        idle();
        total++; if (tx_empty !== 1'b1 || tx_rdata !== '0) $display("FAIL t1_drained act=%b/%h exp=1/0", tx_empty, tx_rdata); else passed++;
    endtask

    task automatic test_join_tx();
        join_mode = 2'd1;
        step();
        for (int i = 0; i < 8; i++) begin
            tx_push = 1'b1; tx_wdata = 32'hA0 + WIDTH'(i);
            step();
            total++; if (tx_full !== (i == 7)) $display("FAIL t2_full_%0d act=%b exp=%b", i, tx_full, (i == 7)); else passed++;
        end
        idle();
        rx_push = 1'b1; rx_wdata = 32'h99;
        step();
        idle();
        total++; if (err[2] !== 1'b1 || rx_empty !== 1'b1 || rx_full !== 1'b1) $display("FAIL t2_rx_zero act=%b/%b/%b exp=1/1/1", err[2], rx_empty, rx_full); else passed++;
        err_clr = 1'b1;
        step();
        idle();
        for (int i = 0; i < 8; i++) begin
            total++; if (tx_rdata !== 32'hA0 + WIDTH'(i)) $display("FAIL t2_rdata_%0d act=%h exp=%h", i, tx_rdata, 32'hA0 + i); else passed++;
            tx_pull = 1'b1;
            step();
        end
        idle();
        total++; if (tx_empty !== 1'b1 || err !== 4'd0) $display("FAIL t2_end act=%b/%b exp=1/0000", tx_empty, err); else passed++;
        join_mode = 2'd0;
        step();
    endtask

    task automatic test_full_push_pull();
        for (int i = 1; i <= 4; i++) begin
            tx_push = 1'b1; tx_wdata = 32'h10 + WIDTH'(i);
            step();
        end
        tx_push = 1'b1; tx_pull = 1'b1; tx_wdata = 32'h55;
        step();
        idle();
        total++; if (tx_full !== 1'b1 || err !== 4'd0) $display("FAIL t3_simul act=%b/%b exp=1/0000", tx_full, err); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (tx_rdata !== head(0)) $display("FAIL t3_rdata_%0d act=%h exp=%h", i, tx_rdata, head(0)); else passed++;
            tx_pull = 1'b1;
            step();
        end
        idle();
        total++; if (tx_empty !== 1'b1) $display("FAIL t3_empty act=%b exp=1", tx_empty); else passed++;
    endtask

    task automatic test_under_with_push();
        tx_pull = 1'b1; tx_push = 1'b1; tx_wdata = 32'h7;
        step();
        idle();
        total++; if (err[1] !== 1'b1 || tx_rdata !== 32'h7 || tx_empty !== 1'b0) $display("FAIL t4 act=%b/%h/%b exp=1/7/0", err[1], tx_rdata, tx_empty); else passed++;
        tx_pull = 1'b1; err_clr = 1'b1;
        step();
        idle();
        total++; if (err !== 4'd0 || tx_empty !== 1'b1) $display("FAIL t4_clr act=%b/%b exp=0000/1", err, tx_empty); else passed++;
    endtask

    task automatic test_join_change();
        tx_pull = 1'b1;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            rx_push = 1'b1; rx_wdata = 32'hC0 + WIDTH'(i);
            step();
        end
        idle();
        total++; if (rx_rdata !== 32'hC0 || rx_empty !== 1'b0) $display("FAIL t5_pre act=%h/%b exp=c0/0", rx_rdata, rx_empty); else passed++;
        join_mode = 2'd2;
        step();
        total++; if (tx_empty !== 1'b1 || rx_empty !== 1'b1 || rx_rdata !== '0) $display("FAIL t5_flush act=%b%b/%h exp=11/0", tx_empty, rx_empty, rx_rdata); else passed++;
        total++; if (err !== 4'b0010 || tx_full !== 1'b1) $display("FAIL t5_err act=%b/%b exp=0010/1", err, tx_full); else passed++;
        err_clr = 1'b1; tx_pull = 1'b1;
        step();
        idle();
        total++; if (err !== 4'b0010) $display("FAIL t5_clr_race act=%b exp=0010", err); else passed++;
        err_clr = 1'b1;
        step();
        idle();
        total++; if (err !== 4'd0) $display("FAIL t5_clr act=%b exp=0000", err); else passed++;
    endtask

    task automatic test_async_reset();
        join_mode = 2'd0;
        step();
        for (int i = 0; i < 2; i++) begin
            tx_push = 1'b1; tx_wdata = 32'hE0 + WIDTH'(i);
            step();
        end
        idle();
        rx_pull = 1'b1;
        step();
        idle();
        total++; if (tx_rdata !== 32'hE0 || err !== 4'b1000) $display("FAIL t6_pre act=%h/%b exp=e0/1000", tx_rdata, err); else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++; if (tx_empty !== 1'b1 || tx_full !== 1'b0 || tx_rdata !== '0 || err !== 4'd0) $display("FAIL t6_async act=%b/%b/%h/%b exp=1/0/0/0000", tx_empty, tx_full, tx_rdata, err); else passed++;
        #1 reset_n = 1'b1;
        model_reset();
        step();
        total++; if (tx_empty !== 1'b1 || rx_empty !== 1'b1) $display("FAIL t6_after act=%b%b exp=11", tx_empty, rx_empty); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) join_mode = 2'($urandom_range(0, 3));
            flush    = ($urandom_range(0, 49) == 0);
            err_clr  = ($urandom_range(0, 9) == 0);
            tx_push  = ($urandom_range(0, 99) < 55);
            tx_pull  = ($urandom_range(0, 99) < 45);
            rx_push  = ($urandom_range(0, 99) < 50);
            rx_pull  = ($urandom_range(0, 99) < 50);
            tx_wdata = $urandom;
            rx_wdata = $urandom;
            step();
            total++; if (tx_rdata !== head(0) || tx_empty !== (tx_q.size() == 0) || tx_full !== (tx_q.size() == cap_of(m_mode, 0)))
                $display("FAIL rnd_tx_%0d act=%h/%b/%b exp=%h/%b/%b", n, tx_rdata, tx_empty, tx_full, head(0), (tx_q.size() == 0), (tx_q.size() == cap_of(m_mode, 0)));
            else passed++;
            total++; if (rx_rdata !== head(1) || rx_empty !== (rx_q.size() == 0) || rx_full !== (rx_q.size() == cap_of(m_mode, 1)))
                $display("FAIL rnd_rx_%0d act=%h/%b/%b exp=%h/%b/%b", n, rx_rdata, rx_empty, rx_full, head(1), (rx_q.size() == 0), (rx_q.size() == cap_of(m_mode, 1)));
            else passed++;
            total++; if (err !== m_err) $display("FAIL rnd_err_%0d act=%b exp=%b", n, err, m_err); else passed++;
`ifdef PIO_FIFO_LEVEL_EN
            total++; if (int'(tx_level) != tx_q.size() || int'(rx_level) != rx_q.size())
                $display("FAIL rnd_level_%0d act=%0d/%0d exp=%0d/%0d", n, tx_level, rx_level, tx_q.size(), rx_q.size());
            else passed++;
`endif
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_tx();
        test_join_tx();
        test_full_push_pull();
        test_under_with_push();
        test_join_change();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
